dma_start_request_arbiter: RTL and testbench
============================================

// Module: dma_start_request_arbiter
// PURPOSE
//  Sits directly downstream of the control-register block. Captures the one-cycle startDMAOp
//  pulses (one bit per internal buffer descriptor, BD) into a pending vector, then round-robin
//  arbitrates them into a single valid/ready request stream (BD index) for the DMA dispatcher.
//  No start pulse is ever lost silently: a pulse is either queued or merged and reported.
// PARAMETERS
//  NUM_INT_BDS   4   number of internal BDs, legal 1..32
//  IDX_W         derived localparam = (NUM_INT_BDS>1) ? clog2(NUM_INT_BDS) : 1; width of the BD index
// PORTS
//  clock         in   1            single clock; all logic on posedge
//  reset         in   1            asynchronous, active-high
//  startDMAOp    in   NUM_INT_BDS  start pulses; each bit held high for 1 cycle; any mix of bits may be high
//  flushPending  in   1            synchronous clear of all pending BDs that are not being offered
//  reqValid      out  1            a BD request is offered
//  reqBdIdx      out  IDX_W        index of the offered BD
//  reqReady      in   1            dispatcher accepts; a handshake occurs when reqValid & reqReady
//  pendingBds    out  NUM_INT_BDS  current pending vector; includes the BD being offered
//  mergeStat     out  NUM_INT_BDS  sticky merge flags; present only with the macro, else tied 0
//  mergeClr      in   NUM_INT_BDS  per-bit clear of mergeStat; ignored when the macro is absent
// BEHAVIOUR
//  Reset: pending=0, reqValid=0, reqBdIdx=0, mergeStat=0, lastGrant=NUM_INT_BDS-1 (BD0 wins first).
//   The asynchronous reset aborts any offer in progress. No state survives reset.
//  Capture: pending[i] is set on the cycle after startDMAOp[i]=1.
//   A grant of BD i and a new start of BD i in the same cycle: pending[i] stays 1 (the new request is kept).
//   A start of BD i while pending[i]=1 and BD i is not being granted: the start merges into the
//   existing request (no double queueing) and is flagged in mergeStat.
//  FSM:
//   IDLE: if (pending & ~offered) != 0, then load reqBdIdx = rr_pick(pending, lastGrant) and go to OFFER;
//    reqValid=1 from the next cycle. Minimum latency: start pulse at cycle N -> reqValid high at N+2.
//   OFFER: reqValid=1. reqBdIdx is held stable until the handshake; the offer is never withdrawn
//    (not by flushPending, not by new starts).
//    On handshake: clear pending[reqBdIdx] and set lastGrant=reqBdIdx.
//    If other BDs are pending (after the clear and any flush), load the next BD via rr_pick and stay in OFFER,
//    giving back-to-back grants. Otherwise go to IDLE with reqValid=0.
//  rr_pick: the first set bit searching upward from lastGrant+1, wrapping modulo NUM_INT_BDS.
//   With NUM_INT_BDS=1 it always returns 0.
//  flushPending=1: clear every pending bit except the offered BD's. The offered BD is still granted.
//   A start in the same cycle as a flush is kept; the start wins over the flush.
//  pendingBds is the registered pending vector (no combinational path from startDMAOp).
// CONFIGURATION
//  DMA_START_MERGE_STAT_EN defined: mergeStat[i] sets on each merge event, clears on mergeClr[i].
//   If a set and a clear hit the same bit in the same cycle, the set wins.
//  Macro undefined: no merge registers; mergeStat=0 and mergeClr is unused. Arbitration is identical.
// STRUCTURE
//  Package dma_start_arb_pkg: FSM state enum {ST_IDLE, ST_OFFER}; clog2 function; MAX_INT_BDS=32.
//  Sub-module dma_rr_pick: purely combinational round-robin picker.
//   Inputs: vector and last pointer. Outputs: index and anyValid.
//  The top level holds the pending/merge registers, the FSM and the output registers.
// TESTING
//  1. Reset, pulse startDMAOp=4'b0001 at cycle 5, reqReady=1 -> reqValid=1 and reqBdIdx=0 at cycle 7;
//     pendingBds=0 at cycle 8.
//  2. startDMAOp=4'b1011 in one cycle, reqReady=1 -> grants in order 0,1,3 on consecutive cycles,
//     then reqValid=0.
//  3. reqReady=0 with BD2 offered; pulse BD3, then BD0 -> reqBdIdx stays 2 until ready.
//     After ready, the order is 3 then 0 (rr from lastGrant=2).
//  4. BD1 pending and not offered; pulse BD1 again -> a single BD1 grant only.
//     With the macro, mergeStat=4'b0010 until mergeClr[1]=1.
//  5. BD0 offered with reqReady=0, BD2 pending; flushPending=1 -> pendingBds=4'b0001.
//     The BD0 handshake still completes, then reqValid=0.
//  6. Assert reset while in OFFER with 3 BDs pending -> reqValid=0 immediately (async)
//     and all state is at reset values.
//     After release, a new BD3 pulse yields reqBdIdx=3.

Source files
------------

// File: rtl/dma_start_request_arbiter_pkg.sv
// Shared types and helpers for the DMA start-request arbiter.
// The optional merge-status feature is enabled with DMA_START_MERGE_STAT_EN.
package dma_start_arb_pkg;

    localparam int MAX_INT_BDS = 32;

    typedef enum logic {
        ST_IDLE,
        ST_OFFER
    } arbState_t;

    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/dma_start_request_arbiter_if.sv
// Valid/ready request stream carrying the index of the BD offered to the DMA dispatcher.
interface dma_start_request_arbiter_if #(
    parameter int IDX_W = 2
);
    logic             reqValid;
    logic [IDX_W-1:0] reqBdIdx;
    logic             reqReady;

    modport master (
        output reqValid,
        output reqBdIdx,
        input  reqReady
    );

    modport slave (
        input  reqValid,
        input  reqBdIdx,
        output reqReady
    );
endinterface

// File: rtl/dma_start_request_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit above lastGrant, wrapping around.
module dma_rr_pick #(
    parameter int NUM_INT_BDS = 4,
    parameter int IDX_W       = 2
) (
    input  logic [NUM_INT_BDS-1:0] vec,
    input  logic [IDX_W-1:0]       last,
    output logic [IDX_W-1:0]       idx,
    output logic                   anyValid
);

    logic [IDX_W-1:0] probe;

    // Walk from the lowest-priority slot (last itself) to the highest (last+1) so the final hit wins.
    always_comb begin
        idx      = '0;
        anyValid = 1'b0;
        probe    = '0;
        for (int k = NUM_INT_BDS; k >= 1; k--) begin
            probe = IDX_W'((int'(last) + k) % NUM_INT_BDS);
            if (vec[probe]) begin
                idx      = probe;
                anyValid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_start_request_arbiter.sv
// Captures startDMAOp pulses into a pending vector and round-robin offers them as a request stream.
// Optional sticky merge flags are built when DMA_START_MERGE_STAT_EN is defined.
module dma_start_request_arbiter
    import dma_start_arb_pkg::*;
#(
    parameter int NUM_INT_BDS = 4,
    localparam int IDX_W      = (NUM_INT_BDS > 1) ? clog2(NUM_INT_BDS) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_INT_BDS-1:0] startDMAOp,
    input  logic                   flushPending,
    dma_start_request_arbiter_if.master req,
    output logic [NUM_INT_BDS-1:0] pendingBds,
    output logic [NUM_INT_BDS-1:0] mergeStat,
    input  logic [NUM_INT_BDS-1:0] mergeClr
);

    arbState_t              state;
    logic [NUM_INT_BDS-1:0] pending;
    logic [IDX_W-1:0]       lastGrant;
    logic                   reqValidQ;
    logic [IDX_W-1:0]       reqBdIdxQ;

    logic                   handshake;
    logic [NUM_INT_BDS-1:0] offeredMask;
    logic [NUM_INT_BDS-1:0] grantMask;
    logic [NUM_INT_BDS-1:0] pendingKept;
    logic [IDX_W-1:0]       pickLast;
    logic [IDX_W-1:0]       pickIdx;
    logic                   pickAny;

    assign handshake   = reqValidQ & req.reqReady;
    assign offeredMask = reqValidQ ? (NUM_INT_BDS'(1) << reqBdIdxQ) : '0;
    assign grantMask   = handshake ? offeredMask : '0;

    // Flush never touches the offered BD; new starts are OR-ed in afterwards so they beat flush and grant.
    assign pendingKept = (flushPending ? (pending & offeredMask) : pending) & ~grantMask;
    assign pickLast    = handshake ? reqBdIdxQ : lastGrant;

    dma_rr_pick #(
        .NUM_INT_BDS(NUM_INT_BDS),
        .IDX_W      (IDX_W)
    ) uRrPick (
        .vec     (pendingKept),
        .last    (pickLast),
        .idx     (pickIdx),
        .anyValid(pickAny)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            pending   <= '0;
            lastGrant <= IDX_W'(NUM_INT_BDS - 1);
            reqValidQ <= 1'b0;
            reqBdIdxQ <= '0;
        end else begin
            pending <= pendingKept | startDMAOp;
            if (handshake) begin
                lastGrant <= reqBdIdxQ;
            end
            case (state)
                ST_IDLE: begin
                    if (pickAny) begin
                        state     <= ST_OFFER;
                        reqValidQ <= 1'b1;
                        reqBdIdxQ <= pickIdx;
                    end
                end
                ST_OFFER: begin
                    // Offer stays stable until accepted, then chains straight into the next pick.
                    if (handshake) begin
                        if (pickAny) begin
                            reqBdIdxQ <= pickIdx;
                        end else begin
                            state     <= ST_IDLE;
                            reqValidQ <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    reqValidQ <= 1'b0;
                end
            endcase
        end
    end

    assign req.reqValid = reqValidQ;
    assign req.reqBdIdx = reqBdIdxQ;
    assign pendingBds   = pending;

`ifdef DMA_START_MERGE_STAT_EN
    logic [NUM_INT_BDS-1:0] mergeEvent;
    logic [NUM_INT_BDS-1:0] mergeStatQ;

    // A start on an already-pending BD that is not being granted this cycle folds into the existing request.
    assign mergeEvent = startDMAOp & pending & ~grantMask;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mergeStatQ <= '0;
        end else begin
            mergeStatQ <= (mergeStatQ & ~mergeClr) | mergeEvent;
        end
    end

    assign mergeStat = mergeStatQ;
`else
    logic unusedMergeClr;

    assign unusedMergeClr = ^mergeClr;
    assign mergeStat      = '0;
`endif

endmodule

// File: tb/tb_dma_start_request_arbiter.sv
// Directed bench for dma_start_request_arbiter (default NUM_INT_BDS=4).
module tb_dma_start_request_arbiter;

    logic       clock;
    logic       reset;
    logic [3:0] startDMAOp;
    logic       flushPending;
    logic [3:0] pendingBds;
    logic [3:0] mergeStat;
    logic [3:0] mergeClr;

    int compared;
    int mismatched;
    int bd1Grants;

    dma_start_request_arbiter_if #(.IDX_W(2)) reqIf ();

    dma_start_request_arbiter #(.NUM_INT_BDS(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .startDMAOp  (startDMAOp),
        .flushPending(flushPending),
        .req         (reqIf),
        .pendingBds  (pendingBds),
        .mergeStat   (mergeStat),
        .mergeClr    (mergeClr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        reset          = 1'b1;
        startDMAOp     = '0;
        flushPending   = 1'b0;
        mergeClr       = '0;
        reqIf.reqReady = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        bd1Grants  = 0;

        // 1: reset state and minimum latency
        doReset();
        check("rst_valid", reqIf.reqValid, 1'b0);
        check("rst_idx", reqIf.reqBdIdx, 2'd0);
        check("rst_pending", pendingBds, 4'b0000);
        check("rst_merge", mergeStat, 4'b0000);
        reqIf.reqReady = 1'b1;
        startDMAOp = 4'b0001;
        tick();
        startDMAOp = '0;
        check("t1_pend_n1", pendingBds, 4'b0001);
        check("t1_valid_n1", reqIf.reqValid, 1'b0);
        tick();
        check("t1_valid_n2", reqIf.reqValid, 1'b1);
        check("t1_idx_n2", reqIf.reqBdIdx, 2'd0);
        tick();
        check("t1_pend_n3", pendingBds, 4'b0000);
        check("t1_valid_n3", reqIf.reqValid, 1'b0);

        // 2: three simultaneous starts, back-to-back grants 0,1,3
        doReset();
        reqIf.reqReady = 1'b1;
        startDMAOp = 4'b1011;
        tick();
        startDMAOp = '0;
        tick();
        check("t2_v0", reqIf.reqValid, 1'b1);
        check("t2_i0", reqIf.reqBdIdx, 2'd0);
        check("t2_p0", pendingBds, 4'b1011);
        tick();
        check("t2_i1", reqIf.reqBdIdx, 2'd1);
        check("t2_p1", pendingBds, 4'b1010);
        tick();
        check("t2_i3", reqIf.reqBdIdx, 2'd3);
        check("t2_v3", reqIf.reqValid, 1'b1);
        tick();
        check("t2_vend", reqIf.reqValid, 1'b0);
        check("t2_pend", pendingBds, 4'b0000);

        // 3: stalled offer of BD2 is held; then rr order 3, 0
        doReset();
        startDMAOp = 4'b0100;
        tick();
        startDMAOp = '0;
        tick();
        check("t3_i2a", reqIf.reqBdIdx, 2'd2);
        startDMAOp = 4'b1000;
        tick();
        startDMAOp = 4'b0001;
        check("t3_i2b", reqIf.reqBdIdx, 2'd2);
        tick();
        startDMAOp = '0;
        tick();
        check("t3_i2c", reqIf.reqBdIdx, 2'd2);
        check("t3_v2c", reqIf.reqValid, 1'b1);
        check("t3_p", pendingBds, 4'b1101);
        reqIf.reqReady = 1'b1;
        tick();
        check("t3_i3", reqIf.reqBdIdx, 2'd3);
        tick();
        check("t3_i0", reqIf.reqBdIdx, 2'd0);
        check("t3_v0", reqIf.reqValid, 1'b1);
        tick();
        check("t3_vend", reqIf.reqValid, 1'b0);

        // 4: repeated start on pending BD1 merges into one grant
        doReset();
        startDMAOp = 4'b0011;
        tick();
        startDMAOp = '0;
        tick();
        check("t4_i0", reqIf.reqBdIdx, 2'd0);
        startDMAOp = 4'b0010;
        tick();
        startDMAOp = '0;
        check("t4_p", pendingBds, 4'b0011);
        tick();
`ifdef DMA_START_MERGE_STAT_EN
        check("t4_mstat", mergeStat, 4'b0010);
`else
        check("t4_mstat", mergeStat, 4'b0000);
`endif
        reqIf.reqReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (reqIf.reqValid === 1'b1 && reqIf.reqBdIdx === 2'd1) bd1Grants++;
            tick();
        end
        check("t4_bd1_grants", bd1Grants, 1);
        check("t4_vend", reqIf.reqValid, 1'b0);
`ifdef DMA_START_MERGE_STAT_EN
        check("t4_mstat_hold", mergeStat, 4'b0010);
`endif
        mergeClr = 4'b0010;
        tick();
        mergeClr = '0;
        check("t4_mstat_clr", mergeStat, 4'b0000);

        // 5: flush keeps only the offered BD, which still completes
        doReset();
        startDMAOp = 4'b0101;
        tick();
        startDMAOp = '0;
        tick();
        check("t5_p_pre", pendingBds, 4'b0101);
        flushPending = 1'b1;
        tick();
        flushPending = 1'b0;
        check("t5_p_flush", pendingBds, 4'b0001);
        check("t5_v", reqIf.reqValid, 1'b1);
        check("t5_i", reqIf.reqBdIdx, 2'd0);
        reqIf.reqReady = 1'b1;
        tick();
        check("t5_vend", reqIf.reqValid, 1'b0);
        check("t5_pend", pendingBds, 4'b0000);

        // 6: asynchronous reset during an offer
        doReset();
        startDMAOp = 4'b0111;
        tick();
        startDMAOp = '0;
        tick();
        check("t6_v_pre", reqIf.reqValid, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("t6_v_async", reqIf.reqValid, 1'b0);
        check("t6_i_async", reqIf.reqBdIdx, 2'd0);
        check("t6_p_async", pendingBds, 4'b0000);
        check("t6_m_async", mergeStat, 4'b0000);
        tick();
        reset = 1'b0;
        tick();
        reqIf.reqReady = 1'b1;
        startDMAOp = 4'b1000;
        tick();
        startDMAOp = '0;
        tick();
        check("t6_v3", reqIf.reqValid, 1'b1);
        check("t6_i3", reqIf.reqBdIdx, 2'd3);
        tick();

        // 7: start of BD0 in its own grant cycle is kept, not merged
        doReset();
        reqIf.reqReady = 1'b1;
        startDMAOp = 4'b0001;
        tick();
        startDMAOp = '0;
        tick();
        check("t7_i0", reqIf.reqBdIdx, 2'd0);
        startDMAOp = 4'b0001;
        tick();
        startDMAOp = '0;
        check("t7_p_kept", pendingBds, 4'b0001);
        check("t7_v_gap", reqIf.reqValid, 1'b0);
        tick();
        check("t7_v_again", reqIf.reqValid, 1'b1);
        check("t7_i_again", reqIf.reqBdIdx, 2'd0);
        check("t7_no_merge", mergeStat, 4'b0000);
        tick();
        check("t7_vend", reqIf.reqValid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
